// File: rtl/mem_scan_reader_if.sv
// Port-B bus between the scan reader and the dual-port RAM.
// The reader only ever reads; the write-side signals are still carried so
// the RAM's port B can be wired straight to this bundle.
interface mem_scan_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] q_b;

  modport master (
    output addr_b,
    output we_b,
    output data_b,
    input  q_b
  );

  modport slave (
    input  addr_b,
    input  we_b,
    input  data_b,
    output q_b
  );
endinterface

// File: rtl/mem_scan_reader.sv
// Read-side sequencer for a 1K x 16 dual-port RAM.
// Walks an address window on port B, captures each word after the RAM read
// latency, and holds it on a registered display bus and four 7-segment
// digits for a fixed dwell before moving on. Port A stays free for a writer.

// Hex nibble to 7-segment code, active-high segments ordered {g,f,e,d,c,b,a}.
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Segment lookup table.
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module mem_scan_reader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,        // multiple of 4, at least 16 for the four digits
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 1023,      // inclusive; may be below START_ADDR (wraps)
  parameter int HOLD_CYCLES = 50000000,  // at least 1
  parameter int READ_LAT    = 1,         // at least 1
  parameter int LOOP        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  mem_scan_reader_if.master    bus,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic [DATA_W-1:0]    display_word,
  output logic                 word_valid,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           lcd1,
  output logic [6:0]           lcd2,
  output logic [6:0]           lcd3,
  output logic [6:0]           lcd4
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]       LAT_LAST  = 32'(READ_LAT - 1);
  localparam logic [31:0]       HOLD_LAST = 32'(HOLD_CYCLES - 1);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cur_addr_r, cur_addr_s;
  logic [DATA_W-1:0]   display_word_r, display_word_s;
  logic                word_valid_r, word_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [31:0]         lat_cnt_r, lat_cnt_s;
  logic [31:0]         hold_cnt_r, hold_cnt_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, next address, capture and dwell counting.
  always_comb begin
    state_s        = state_r;
    cur_addr_s     = cur_addr_r;
    display_word_s = display_word_r;
    word_valid_s   = 1'b0;
    lat_cnt_s      = lat_cnt_r;
    hold_cnt_s     = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cur_addr_s = START_A;
          state_s    = ST_ISSUE;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_s = 32'd0;
        state_s   = ST_WAIT;
      end
      ST_WAIT: begin
        // The read in flight always completes; pause is not looked at here.
        if (lat_cnt_r == LAT_LAST) begin
          display_word_s = bus.q_b;
          word_valid_s   = 1'b1;
          hold_cnt_s     = 32'd0;
          state_s        = ST_HOLD;
        end else begin
          lat_cnt_s      = lat_cnt_r + 32'd1;
        end
      end
      ST_HOLD: begin
        if (pause) begin
          hold_cnt_s = hold_cnt_r;
        end else if (hold_cnt_r == HOLD_LAST) begin
          if (cur_addr_r != END_A) begin
            cur_addr_s = cur_addr_r + ADDR_ONE;  // wraps modulo 2^ADDR_W
            state_s    = ST_ISSUE;
          end else if (LOOP != 0) begin
            cur_addr_s = START_A;
            state_s    = ST_ISSUE;
          end else begin
            state_s    = ST_DONE;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + 32'd1;
        end
      end
      ST_DONE: begin
        if (start) begin
          cur_addr_s = START_A;
          state_s    = ST_ISSUE;
        end else begin
          state_s    = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_ISSUE) || (state_s == ST_WAIT) || (state_s == ST_HOLD);
    done_s = (state_s == ST_DONE);
  end

  // Datapath and status registers; outputs come straight from these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_r     <= START_A;
      display_word_r <= {DATA_W{1'b0}};
      word_valid_r   <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      lat_cnt_r      <= 32'd0;
      hold_cnt_r     <= 32'd0;
    end else begin
      cur_addr_r     <= cur_addr_s;
      display_word_r <= display_word_s;
      word_valid_r   <= word_valid_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      lat_cnt_r      <= lat_cnt_s;
      hold_cnt_r     <= hold_cnt_s;
    end
  end

  // The RAM address tracks the displayed address, so it is stable through
  // ISSUE and WAIT and never changes while a dwell is paused.
  assign bus.addr_b    = cur_addr_r;
  assign bus.we_b      = 1'b0;
  assign bus.data_b    = {DATA_W{1'b0}};
  assign cur_addr      = cur_addr_r;
  assign display_word  = display_word_r;
  assign word_valid    = word_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;

  hexTo7Seg u_seg1 (.hex(display_word_r[3:0]),   .seg(lcd1));
  hexTo7Seg u_seg2 (.hex(display_word_r[7:4]),   .seg(lcd2));
  hexTo7Seg u_seg3 (.hex(display_word_r[11:8]),  .seg(lcd3));
  hexTo7Seg u_seg4 (.hex(display_word_r[15:12]), .seg(lcd4));

endmodule
